// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and stall scheduler for the 5-stage pipeline. It produces the
// execute-stage forwarding selects, load-use bubbles and branch flushes. It
// holds the whole pipeline while a multi-cycle data-memory access is pending,
// with a timeout into a terminal ERROR state. It also keeps saturating
// stall/flush performance counters.
//
// Ports
//   clk, reset                    clock, async active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E          source registers in Decode / Execute
//   RdE/RdM/RdW                   destination registers in Execute/Memory/Writeback
//   RegWriteM/RegWriteW           write enables in Memory / Writeback
//   ResultSrcE                    Execute result select (2'b01 = load)
//   PCSrcE                        taken branch/jump resolved in Execute
//   mem_req_M, mem_ready          data-memory request / completion
//   perf_clr                      synchronous clear of both counters
//   StallF/D/E/M, FlushD/E        pipeline register controls
//   ForwardAE/BE                  00 regfile, 01 ResultW, 10 ALUResultM
//   mem_timeout_err               sticky memory timeout flag
//   state_o                       00 RUN, 01 MEM_WAIT, 10 ERROR
//   stall_cycles, flush_count     saturating performance counters
//
// state    | meaning
// RUN      | normal flow; single-cycle memory accesses complete here
// MEM_WAIT | data memory busy, whole pipeline held, waitCnt counts wait cycles
// ERROR    | memory timed out; pipeline held until reset
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              mem_req_M,
    input  logic              mem_ready,
    input  logic              perf_clr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mem_timeout_err,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [REG_AW-1:0] REG_ZERO   = '0;

    state_t     state, nextState;
    logic [7:0] waitCnt, nextWaitCnt;
    logic       setErr;
    logic       memHold;
    logic       loadUse;

    // Hold covers the first (RUN) cycle of a slow access as well, so the
    // request is held in Memory from the very cycle it is issued.
    always_comb begin
        memHold = 1'b0;
        case (state)
            RUN:      memHold = mem_req_M && !mem_ready;
            MEM_WAIT: memHold = !mem_ready;
            ERROR:    memHold = 1'b1;
            default:  memHold = 1'b0;
        endcase
    end

    assign loadUse = (ResultSrcE == 2'b01) && (RdE != REG_ZERO) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        setErr      = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_M && !mem_ready) begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    nextState   = RUN;
                    nextWaitCnt = 8'd0;
                end else if (waitCnt >= TIMEOUT_VAL) begin
                    nextState = ERROR;
                    setErr    = 1'b1;
                end else begin
                    nextWaitCnt = waitCnt + 8'd1;
                end
            end
            ERROR:   nextState = ERROR;
            default: begin
                nextState   = RUN;
                nextWaitCnt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RUN;
            waitCnt         <= 8'd0;
            mem_timeout_err <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (setErr) begin
                mem_timeout_err <= 1'b1;
            end
        end
    end

    assign state_o = state;

    // Control outputs are forced low while reset is held so the pipeline
    // registers see a clean, inactive control set during reset.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            if (RegWriteM && (RdM != REG_ZERO) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != REG_ZERO) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RdM != REG_ZERO) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != REG_ZERO) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end

            // A held pipeline must not flush: the branch and load-use terms
            // are simply re-evaluated once the memory access lets go.
            if (memHold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loadUse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (StallF && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (FlushD && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, mem_req_M, mem_ready, perf_clr;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout_err;
    logic [1:0] state_o;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .mem_req_M(mem_req_M), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout_err(mem_timeout_err), .state_o(state_o),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comb vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}
    localparam logic [9:0] NONE   = 10'b0000_00_00_00;
    localparam logic [9:0] ST_ALL = 10'b1111_00_00_00;
    localparam logic [9:0] LU     = 10'b1100_01_00_00;
    localparam logic [9:0] BR     = 10'b0000_11_00_00;

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwM, rwW;
        logic [1:0] rsrc;
        logic       pc, mreq, mrdy;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        logic [9:0] comb;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[16];
    int   errors = 0;
    int   checks = 0;
    int   stallExp = 0;
    int   flushExp = 0;

    function automatic vec_t mkVec(input logic [4:0] a, b, c, d, e, f, g,
                                   input logic h, i, input logic [1:0] j,
                                   input logic k, l, m, input logic [9:0] x);
        vec_t v;
        v.rs1D = a; v.rs2D = b; v.rs1E = c; v.rs2E = d;
        v.rdE = e; v.rdM = f; v.rdW = g; v.rwM = h; v.rwW = i;
        v.rsrc = j; v.pc = k; v.mreq = l; v.mrdy = m; v.exp = x;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [9:0] combNow();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};
    endfunction

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
        mem_req_M = 0; mem_ready = 0; perf_clr = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc(input string tag, input logic [9:0] eComb,
                       input logic [1:0] eState, input logic eErr);
        exp_t e;
        expQ.push_back('{comb: eComb, st: eState, err: eErr});
        #2;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = expQ.pop_front();
        check({tag, " comb"}, 32'(combNow()), 32'(e.comb));
        if (perf_clr) begin
            stallExp = 0;
            flushExp = 0;
        end else begin
            if (e.comb[9] && stallExp != CNT_MAX) stallExp++;
            if (e.comb[5] && flushExp != CNT_MAX) flushExp++;
        end
        @(posedge clk);
        #1;
        check({tag, " state"}, 32'(state_o), 32'(e.st));
        check({tag, " err"}, 32'(mem_timeout_err), 32'(e.err));
        check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(stallExp));
        check({tag, " flush_count"}, 32'(flush_count), 32'(flushExp));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkVec(0, 0, 5, 0,  0, 5, 5,   1, 1, 2'b00, 0, 0, 0, 10'b0000_00_10_00);
        vecs[1]  = mkVec(0, 0, 5, 0,  0, 5, 5,   0, 1, 2'b00, 0, 0, 0, 10'b0000_00_01_00);
        vecs[2]  = mkVec(0, 0, 5, 0,  0, 0, 0,   1, 1, 2'b00, 0, 0, 0, NONE);
        vecs[3]  = mkVec(0, 0, 0, 0,  0, 0, 0,   1, 1, 2'b00, 0, 0, 0, NONE);
        vecs[4]  = mkVec(0, 0, 9, 7,  0, 7, 9,   1, 1, 2'b00, 0, 0, 0, 10'b0000_00_01_10);
        vecs[5]  = mkVec(0, 0, 0, 12, 0, 12, 12, 1, 1, 2'b00, 0, 0, 0, 10'b0000_00_00_10);
        vecs[6]  = mkVec(0, 0, 4, 0,  0, 4, 0,   0, 0, 2'b00, 0, 0, 0, NONE);
        vecs[7]  = mkVec(0, 3, 0, 0,  3, 0, 0,   0, 0, 2'b01, 0, 0, 0, LU);
        vecs[8]  = mkVec(0, 3, 0, 0,  3, 0, 0,   0, 0, 2'b00, 0, 0, 0, NONE);
        vecs[9]  = mkVec(6, 0, 0, 0,  6, 0, 0,   0, 0, 2'b01, 0, 0, 0, LU);
        vecs[10] = mkVec(0, 0, 0, 0,  0, 0, 0,   0, 0, 2'b01, 0, 0, 0, NONE);
        vecs[11] = mkVec(3, 0, 0, 0,  3, 0, 0,   0, 0, 2'b10, 0, 0, 0, NONE);
        vecs[12] = mkVec(0, 3, 0, 0,  3, 0, 0,   0, 0, 2'b01, 1, 0, 0, BR);
        vecs[13] = mkVec(0, 0, 0, 0,  0, 0, 0,   0, 0, 2'b00, 1, 0, 0, BR);
        vecs[14] = mkVec(8, 0, 8, 0,  8, 8, 0,   1, 0, 2'b01, 0, 0, 0, 10'b1100_01_10_00);
        vecs[15] = mkVec(0, 0, 0, 0,  0, 0, 0,   0, 0, 2'b00, 1, 1, 1, BR);

        // Reset: controls must stay low even with hazards on the inputs.
        idle();
        reset = 1'b0;
        RegWriteM = 1; RdM = 5; Rs1E = 5; PCSrcE = 1;
        #3;
        check("reset comb", 32'(combNow()), 32'(NONE));
        check("reset state", 32'(state_o), 32'd0);
        check("reset err", 32'(mem_timeout_err), 32'd0);
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
        check("reset flush_count", 32'(flush_count), 32'd0);
        @(negedge clk);
        idle();
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D;
            Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
            RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
            RegWriteM = vecs[i].rwM; RegWriteW = vecs[i].rwW;
            ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pc;
            mem_req_M = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            cyc($sformatf("vec%0d", i), vecs[i].exp, 2'b00, 1'b0);
        end

        // Memory wait of 3 cycles, branch during the wait must not flush.
        idle();
        perf_clr = 1;
        cyc("clr", NONE, 2'b00, 1'b0);
        perf_clr = 0;
        mem_req_M = 1;
        cyc("mw1", ST_ALL, 2'b01, 1'b0);
        PCSrcE = 1;
        cyc("mw2", ST_ALL, 2'b01, 1'b0);
        PCSrcE = 0;
        cyc("mw3", ST_ALL, 2'b01, 1'b0);
        mem_ready = 1;
        cyc("mw4", NONE, 2'b00, 1'b0);
        check("memwait total stalls", 32'(stall_cycles), 32'd3);
        check("memwait no flush", 32'(flush_count), 32'd0);

        // Timeout: 16 stalled cycles then ERROR, sticky past mem_ready.
        idle();
        mem_req_M = 1;
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("to%0d", i), ST_ALL, (i == 15) ? 2'b10 : 2'b01, i == 15);
        end
        mem_ready = 1;
        cyc("err rdy", ST_ALL, 2'b10, 1'b1);
        mem_req_M = 0; PCSrcE = 1;
        cyc("err hold", ST_ALL, 2'b10, 1'b1);

        // Async reset inside a cycle, no clock edge needed.
        RegWriteM = 1; RdM = 5; Rs1E = 5;
        #3;
        reset = 1'b0;
        #1;
        check("areset comb", 32'(combNow()), 32'(NONE));
        check("areset state", 32'(state_o), 32'd0);
        check("areset err", 32'(mem_timeout_err), 32'd0);
        check("areset stall_cycles", 32'(stall_cycles), 32'd0);
        stallExp = 0;
        flushExp = 0;
        @(negedge clk);
        idle();
        reset = 1'b1;
        cyc("post reset", NONE, 2'b00, 1'b0);

        // Saturation and clear.
        RdE = 3; Rs2D = 3; ResultSrcE = 2'b01;
        for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), LU, 2'b00, 1'b0);
        check("stall saturated", 32'(stall_cycles), 32'd15);
        perf_clr = 1;
        cyc("clr under stall", LU, 2'b00, 1'b0);
        check("clr overrides inc", 32'(stall_cycles), 32'd0);
        perf_clr = 0;
        cyc("after clr", LU, 2'b00, 1'b0);
        idle();
        PCSrcE = 1;
        for (int i = 0; i < 17; i++) cyc($sformatf("fsat%0d", i), BR, 2'b00, 1'b0);
        check("flush saturated", 32'(flush_count), 32'd15);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and stall scheduler for the 5-stage pipeline (17-bit instructions, 19-bit registers, 12-bit PC). It generates the execute-stage forwarding selects, load-use stalls and branch flushes. It also sequences multi-cycle data-memory accesses through a RUN/MEM_WAIT/ERROR state machine with a timeout. It keeps saturating performance counters for stall and flush cycles. It sits beside the pipeline registers and drives their stall/flush controls.

Parameters:
REG_AW, 5, register address width
MEM_TIMEOUT, 15, max consecutive memory-wait cycles before ERROR (1..255)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
reset  in  1  async active-low reset
Rs1D, Rs2D  in  REG_AW  source regs of the instruction in Decode
Rs1E, Rs2E  in  REG_AW  source regs of the instruction in Execute
RdE, RdM, RdW  in  REG_AW  destination regs in Execute, Memory and Writeback
RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback
ResultSrcE  in  2  result select in Execute; 2'b01 = load
PCSrcE  in  1  branch/jump taken, resolved in Execute
mem_req_M  in  1  data-memory access in Memory stage
mem_ready  in  1  data memory completes the access this cycle
perf_clr  in  1  synchronous clear of both counters
StallF, StallD, StallE, StallM  out  1  hold PC / Decode / Execute / Memory registers
FlushD, FlushE  out  1  zero the Decode / Execute registers on the next edge
ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 ResultW, 10 ALUResultM
mem_timeout_err  out  1  sticky timeout flag
state_o  out  2  00 RUN, 01 MEM_WAIT, 10 ERROR
stall_cycles  out  CNT_W  cycles with StallF=1, saturating
flush_count  out  CNT_W  cycles with a branch flush, saturating

Behaviour:
- Reset (reset=0, async): state=RUN, wait_cnt=0, mem_timeout_err=0, both counters=0. While reset is low, all Stall*, Flush* and Forward* outputs are 0.
- Forwarding (combinational, 0 latency), shown for A; B is identical using Rs2E:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - Memory stage wins when both match. Register 0 is never forwarded.
- Event terms:
  - mem_hold = (RUN && mem_req_M && !mem_ready) || (MEM_WAIT && !mem_ready) || ERROR
  - lu = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)
- Priority of the combinational outputs:
  1. mem_hold: StallF/D/E/M=1, FlushD=FlushE=0. Branch and load-use are ignored this cycle; they re-evaluate once the pipeline moves.
  2. else PCSrcE: FlushD=FlushE=1, all stalls 0. A load-use hazard in the same cycle is discarded, since the Decode instruction is flushed.
  3. else lu: StallF=StallD=1, FlushE=1, StallE=StallM=0. This is a 1-cycle bubble.
  4. else all 0.
- FSM, updated on the clk rising edge:
  - RUN -> MEM_WAIT when mem_req_M && !mem_ready; wait_cnt<=1.
  - MEM_WAIT -> RUN when mem_ready; wait_cnt<=0. There is no stall in the mem_ready cycle.
  - MEM_WAIT, !mem_ready, wait_cnt<MEM_TIMEOUT: stay in MEM_WAIT; wait_cnt++.
  - MEM_WAIT, !mem_ready, wait_cnt==MEM_TIMEOUT: go to ERROR; mem_timeout_err<=1.
  - ERROR is terminal until reset. It stalls all stages and ignores mem_ready.
  - mem_req_M && mem_ready in RUN: single-cycle access, stay in RUN, no stall.
- Counters:
  - stall_cycles increments on every edge where StallF=1; flush_count increments on every edge where FlushD=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - perf_clr=1 sets both to 0 at the edge and overrides that cycle's increment.
- Reset asserted mid-MEM_WAIT or in ERROR immediately returns to RUN with all outputs 0. No partial state is retained.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Drop RegWriteM -> ForwardAE=01. Set RdM=RdW=0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=3, Rs2D=3 for one cycle -> StallF=StallD=FlushE=1 that cycle, stall_cycles 0->1. Next cycle ResultSrcE=00 -> all 0.
- Branch vs load-use: PCSrcE=1 with the lu condition true -> FlushD=FlushE=1, StallF=0; flush_count +1, stall_cycles unchanged.
- Memory wait: mem_req_M=1, mem_ready=0 for 3 cycles, then 1 -> all stalls=1 for 3 cycles, state_o 00->01->01->01->00, stall_cycles=3. PCSrcE=1 during the wait produces no flush.
- Timeout: mem_req_M=1, mem_ready held 0 -> ERROR (state_o=10) after 16 stalled cycles with MEM_TIMEOUT=15. mem_timeout_err=1 persists after mem_ready=1. Async reset low mid-cycle -> state_o=00, err=0, outputs 0 without a clock edge.
- Saturation and clear: with CNT_W=4, hold stall for 20 cycles -> stall_cycles=15. perf_clr=1 with stall active -> 0 on the next edge.
